// File: rtl/ddr5_write_sequencer.sv
// DDR5 write burst sequencer: frames preamble, data, burst-chop pad, CRC, interamble
// and postamble on the DQ/DQS lanes, with a one-deep queue for the next request.
`timescale 1ns/1ps
module ddr5_write_sequencer #(
    parameter int DQ_W = 8,
    localparam int DM_W = DQ_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic              i_bc8,
    input  logic              i_crc_en,
    input  logic [1:0]        i_pre_len,
    input  logic [2*DQ_W-1:0] i_wr_data,
    input  logic [2*DM_W-1:0] i_wr_dm,
    input  logic [2*DQ_W-1:0] i_crc_code,
    output logic [2*DQ_W-1:0] o_dq,
    output logic [2*DM_W-1:0] o_dm,
    output logic [1:0]        o_dqs,
    output logic              o_dq_oe,
    output logic              o_dqs_oe,
    output logic              o_data_rd,
    output logic              o_crc_clr,
    output logic              o_crc_en,
    output logic [2*DQ_W-1:0] o_crc_data,
    output logic              o_busy,
    output logic              o_overflow,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_DATA  = 3'd2,
        S_PAD   = 3'd3,
        S_CRC   = 3'd4,
        S_INTER = 3'd5,
        S_POST  = 3'd6
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       act_bc8;
    logic       act_crc;
    logic       pend_v;
    logic       pend_bc8;
    logic       pend_crc;
    logic [1:0] pend_pre;
    logic       overflow;

    logic       last;
    logic       active;
    logic       req_busy;
    logic       at_decision;
    logic       post_end;
    logic       eff_v;
    logic       eff_bc8;
    logic       eff_crc;
    logic [1:0] eff_pre;
    logic       promote;

    assign last     = (cnt == 3'd0);
    assign active   = state inside {S_PRE, S_DATA, S_PAD, S_CRC, S_INTER, S_POST};
    assign req_busy = i_wr_en && active;

    // End of burst: last DATA (BL16, no CRC), last PAD (BC8, no CRC) or the CRC beat.
    assign at_decision = ((state == S_DATA) && last && !act_bc8 && !act_crc) ||
                         ((state == S_PAD) && last && !act_crc) ||
                         (state == S_CRC);
    assign post_end    = (state == S_POST) && last;

    // A request arriving on the decision cycle itself is treated as already pending.
    assign eff_v   = pend_v || i_wr_en;
    assign eff_bc8 = pend_v ? pend_bc8 : i_bc8;
    assign eff_crc = pend_v ? pend_crc : i_crc_en;
    assign eff_pre = pend_v ? pend_pre : i_pre_len;
    assign promote = (at_decision || post_end) && eff_v;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            act_bc8  <= 1'b0;
            act_crc  <= 1'b0;
            pend_v   <= 1'b0;
            pend_bc8 <= 1'b0;
            pend_crc <= 1'b0;
            pend_pre <= 2'd0;
            overflow <= 1'b0;
        end else begin
            overflow <= req_busy && pend_v;

            if (promote || !active) begin
                pend_v <= 1'b0;
            end else if (req_busy && !pend_v) begin
                pend_v   <= 1'b1;
                pend_bc8 <= i_bc8;
                pend_crc <= i_crc_en;
                pend_pre <= i_pre_len;
            end

            if (at_decision || post_end) begin
                if (eff_v) begin
                    state   <= at_decision ? S_INTER : S_PRE;
                    cnt     <= {1'b0, eff_pre};
                    act_bc8 <= eff_bc8;
                    act_crc <= eff_crc;
                end else if (at_decision) begin
                    state <= S_POST;
                    cnt   <= 3'd1;
                end else begin
                    state <= S_IDLE;
                    cnt   <= 3'd0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_wr_en) begin
                            state   <= S_PRE;
                            cnt     <= {1'b0, i_pre_len};
                            act_bc8 <= i_bc8;
                            act_crc <= i_crc_en;
                        end
                    end
                    S_PRE, S_INTER: begin
                        if (last) begin
                            state <= S_DATA;
                            cnt   <= act_bc8 ? 3'd3 : 3'd7;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                    S_DATA: begin
                        if (!last) begin
                            cnt <= cnt - 3'd1;
                        end else if (act_bc8) begin
                            state <= S_PAD;
                            cnt   <= 3'd3;
                        end else begin
                            state <= S_CRC;
                            cnt   <= 3'd0;
                        end
                    end
                    S_PAD: begin
                        if (!last) begin
                            cnt <= cnt - 3'd1;
                        end else begin
                            state <= S_CRC;
                            cnt   <= 3'd0;
                        end
                    end
                    S_POST: begin
                        cnt <= cnt - 3'd1;
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= 3'd0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        o_dq       = '0;
        o_dm       = '0;
        o_dqs      = 2'b00;
        o_dq_oe    = 1'b0;
        o_dqs_oe   = 1'b0;
        o_data_rd  = 1'b0;
        o_crc_clr  = 1'b0;
        o_crc_en   = 1'b0;
        o_crc_data = '0;
        case (state)
            S_PRE, S_INTER: begin
                o_dqs_oe  = 1'b1;
                o_dqs     = last ? 2'b10 : 2'b00;
                o_crc_clr = last;
            end
            S_DATA: begin
                o_dq       = i_wr_data;
                o_dm       = i_wr_dm;
                o_data_rd  = 1'b1;
                o_dq_oe    = 1'b1;
                o_dqs_oe   = 1'b1;
                o_dqs      = 2'b10;
                o_crc_en   = act_crc;
                o_crc_data = i_wr_data;
            end
            S_PAD: begin
                o_dq       = '1;
                o_dq_oe    = 1'b1;
                o_dqs_oe   = 1'b1;
                o_dqs      = 2'b10;
                o_crc_en   = act_crc;
                o_crc_data = '1;
            end
            S_CRC: begin
                o_dq     = i_crc_code;
                o_dq_oe  = 1'b1;
                o_dqs_oe = 1'b1;
                o_dqs    = 2'b10;
            end
            S_POST: begin
                o_dqs_oe = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_busy     = (state != S_IDLE) || pend_v;
    assign o_overflow = overflow;
    assign o_state    = state;

endmodule
